// File: rtl/versat_databus_arbiter.sv
// Databus arbiter: N masters share one downstream burst port, and the owner is locked until its last beat.
// Define VERSAT_ARB_ROUND_ROBIN_EN to select round-robin arbitration; the default is fixed priority.
module versat_databus_arbiter #(
  parameter int N_MASTERS  = 3,
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             databus_valid,
  output logic [N_MASTERS-1:0]             databus_ready,
  input  logic [N_MASTERS*AXI_ADDR_W-1:0]  databus_addr,
  input  logic [N_MASTERS*DATA_W-1:0]      databus_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]    databus_wstrb,
  input  logic [N_MASTERS*8-1:0]           databus_len,
  output logic [DATA_W-1:0]                databus_rdata,
  output logic [N_MASTERS-1:0]             databus_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [AXI_ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]                m_wdata,
  output logic [DATA_W/8-1:0]              m_wstrb,
  output logic [7:0]                       m_len,
  input  logic [DATA_W-1:0]                m_rdata,
  input  logic                             m_last,
  output logic [N_MASTERS-1:0]             grant,
  output logic                             busy
);

  localparam int IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] winner;
  logic            own;
  logic            burst_end;

  // Gating with rst keeps the outputs quiet in the same cycle that reset is raised.
  assign own       = (state_q == StOwn) && !rst;
  assign burst_end = m_valid && m_ready && m_last;
  assign busy      = own;
  assign databus_rdata = m_rdata;

`ifdef VERSAT_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = (int'(ptr_q) + i) % N_MASTERS;
      if (!found && databus_valid[idx]) begin
        winner = IdxW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (own && burst_end) begin
      ptr_d = (owner_q == IdxW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Scanning downwards lets the lowest requesting index overwrite the others.
  always_comb begin
    winner = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (databus_valid[i]) begin
        winner = IdxW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (|databus_valid) begin
          owner_d = winner;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (burst_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    grant         = '0;
    databus_ready = '0;
    databus_last  = '0;
    m_valid       = 1'b0;
    m_addr        = '0;
    m_wdata       = '0;
    m_wstrb       = '0;
    m_len         = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (own && (owner_q == IdxW'(i))) begin
        grant[i]         = 1'b1;
        databus_ready[i] = m_ready;
        databus_last[i]  = m_last;
        m_valid          = databus_valid[i];
        m_addr           = databus_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
        m_wdata          = databus_wdata[i*DATA_W +: DATA_W];
        m_wstrb          = databus_wstrb[i*(DATA_W/8) +: (DATA_W/8)];
        m_len            = databus_len[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Cycle-table bench for versat_databus_arbiter (3 masters) plus an arbitration-mode sequence.
`timescale 1ns/1ps
module tb_versat_databus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  databus_valid;
  logic [2:0]  databus_ready;
  logic [95:0] databus_addr;
  logic [95:0] databus_wdata;
  logic [11:0] databus_wstrb;
  logic [23:0] databus_len;
  logic [31:0] databus_rdata;
  logic [2:0]  databus_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [7:0]  m_len;
  logic [31:0] m_rdata;
  logic        m_last;
  logic [2:0]  grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] addr_tab  [3] = '{32'h0000_0800, 32'h0000_1000, 32'h0000_2000};
  logic [31:0] wdata_tab [3] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2};
  logic [3:0]  wstrb_tab [3] = '{4'hF, 4'h0, 4'h3};
  logic [7:0]  len_tab   [3] = '{8'd3, 8'd3, 8'd0};

  versat_databus_arbiter #(.N_MASTERS(3), .AXI_ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_wdata(databus_wdata),
    .databus_wstrb(databus_wstrb), .databus_len(databus_len),
    .databus_rdata(databus_rdata), .databus_last(databus_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len), .m_rdata(m_rdata), .m_last(m_last),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] valid;
    logic       mrdy;
    logic       mlast;
    logic [2:0] e_grant;
    logic       e_busy;
    logic       e_mvalid;
    logic [2:0] e_ready;
    logic [2:0] e_last;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one cycle's inputs, checks outputs before the rising edge, then advances a cycle.
  task automatic apply(input vec_t v, input string tag);
    int k;
    rst           = v.rst;
    databus_valid = v.valid;
    m_ready       = v.mrdy;
    m_last        = v.mlast;
    m_rdata       = 32'h5A00_0000 | 32'($urandom_range(0, 65535));
    #1;
    k = -1;
    for (int i = 0; i < 3; i++) if (v.e_grant[i]) k = i;
    chk({tag, "_grant"}, 64'(grant), 64'(v.e_grant));
    chk({tag, "_busy"},  64'(busy), 64'(v.e_busy));
    chk({tag, "_mvalid"}, 64'(m_valid), 64'(v.e_mvalid));
    chk({tag, "_ready"}, 64'(databus_ready), 64'(v.e_ready));
    chk({tag, "_last"},  64'(databus_last), 64'(v.e_last));
    chk({tag, "_addr"},  64'(m_addr),  (k < 0) ? 64'd0 : 64'(addr_tab[k]));
    chk({tag, "_wdata"}, 64'(m_wdata), (k < 0) ? 64'd0 : 64'(wdata_tab[k]));
    chk({tag, "_wstrb"}, 64'(m_wstrb), (k < 0) ? 64'd0 : 64'(wstrb_tab[k]));
    chk({tag, "_len"},   64'(m_len),   (k < 0) ? 64'd0 : 64'(len_tab[k]));
    chk({tag, "_rdata"}, 64'(databus_rdata), 64'(m_rdata));
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t       tab [41];
  vec_t       v;
  logic [2:0] seq_grant [8];
  logic [2:0] seq_valid;

  initial begin
    // rst valid mrdy mlast | grant busy mvalid ready last
    tab[0]  = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // single request from master 1, 4 beats
    tab[1]  = '{0, 3'b010, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[2]  = '{0, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000};
    tab[3]  = '{0, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000};
    tab[4]  = '{0, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000};
    tab[5]  = '{0, 3'b010, 1, 1, 3'b010, 1, 1, 3'b010, 3'b010};
    tab[6]  = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // m_last without handshake is ignored
    tab[7]  = '{0, 3'b001, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[8]  = '{0, 3'b001, 0, 1, 3'b001, 1, 1, 3'b000, 3'b001};
    tab[9]  = '{0, 3'b001, 1, 1, 3'b001, 1, 1, 3'b001, 3'b001};
    tab[10] = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // owner re-requests the cycle its burst ends; m_last ignored in idle
    tab[11] = '{0, 3'b010, 1, 1, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[12] = '{0, 3'b010, 1, 1, 3'b010, 1, 1, 3'b010, 3'b010};
    tab[13] = '{0, 3'b010, 1, 1, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[14] = '{0, 3'b010, 1, 1, 3'b010, 1, 1, 3'b010, 3'b010};
    tab[15] = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // lock: owner 0 drops valid after beat 1, master 2 waits
    tab[16] = '{0, 3'b001, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[17] = '{0, 3'b001, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000};
    tab[18] = '{0, 3'b100, 1, 0, 3'b001, 1, 0, 3'b001, 3'b000};
    tab[19] = '{0, 3'b101, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000};
    tab[20] = '{0, 3'b101, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000};
    tab[21] = '{0, 3'b101, 1, 1, 3'b001, 1, 1, 3'b001, 3'b001};
    tab[22] = '{0, 3'b100, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[23] = '{0, 3'b100, 1, 1, 3'b100, 1, 1, 3'b100, 3'b100};
    tab[24] = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // backpressure: m_ready low for 5 cycles mid-burst
    tab[25] = '{0, 3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[26] = '{0, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000};
    for (int i = 27; i < 32; i++) tab[i] = '{0, 3'b010, 0, 0, 3'b010, 1, 1, 3'b000, 3'b000};
    tab[32] = '{0, 3'b010, 1, 1, 3'b010, 1, 1, 3'b010, 3'b010};
    tab[33] = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    // reset mid-burst, then re-arbitration
    tab[34] = '{0, 3'b011, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[35] = '{0, 3'b011, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000};
    tab[36] = '{1, 3'b011, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[37] = '{0, 3'b011, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};
    tab[38] = '{0, 3'b011, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000};
    tab[39] = '{0, 3'b011, 1, 1, 3'b001, 1, 1, 3'b001, 3'b001};
    tab[40] = '{0, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000};

    for (int i = 0; i < 3; i++) begin
      databus_addr[i*32 +: 32]  = addr_tab[i];
      databus_wdata[i*32 +: 32] = wdata_tab[i];
      databus_wstrb[i*4 +: 4]   = wstrb_tab[i];
      databus_len[i*8 +: 8]     = len_tab[i];
    end
    rst = 1'b1;
    databus_valid = '0;
    m_ready = 1'b0;
    m_last  = 1'b0;
    m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 41; i++) apply(tab[i], $sformatf("v%0d", i));

    // Contention with one-beat bursts after a fresh reset (pointer back at 0).
`ifdef VERSAT_ARB_ROUND_ROBIN_EN
    seq_valid = 3'b111;
    seq_grant = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
`else
    seq_valid = 3'b110;
    seq_grant = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
`endif
    v = '{1, 3'b000, 1, 1, 3'b000, 0, 0, 3'b000, 3'b000};
    apply(v, "arb_rst");
    for (int i = 0; i < 8; i++) begin
      v = '{0, seq_valid, 1, 1, seq_grant[i], |seq_grant[i], |seq_grant[i],
            seq_grant[i], seq_grant[i]};
      apply(v, $sformatf("arb%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/versat_databus_arbiter.md
VERSAT_DATABUS_ARBITER -- requirements
Module: versat_databus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3, number of databus master ports.
REQ-002 SHALL have parameter AXI_ADDR_W, default 32, address width per port.
REQ-003 SHALL have parameter DATA_W, default 32, data width per port.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 databus_valid  input  N_MASTERS  per-master request valid.
REQ-007 databus_ready  output  N_MASTERS  per-master beat accept.
REQ-008 databus_addr  input  N_MASTERS*AXI_ADDR_W  per-master address, master i at bits [i*AXI_ADDR_W +: AXI_ADDR_W].
REQ-009 databus_wdata  input  N_MASTERS*DATA_W  per-master write data.
REQ-010 databus_wstrb  input  N_MASTERS*DATA_W/8  per-master write strobe; all-zero means read.
REQ-011 databus_len  input  N_MASTERS*8  per-master burst length.
REQ-012 databus_rdata  output  DATA_W  read data, broadcast to all masters.
REQ-013 databus_last  output  N_MASTERS  per-master last-beat indication.
REQ-014 m_valid, m_ready, m_addr, m_wdata, m_wstrb, m_len, m_rdata, m_last: single downstream port; m_valid/addr/wdata/wstrb/len outputs, m_ready/rdata/last inputs, widths 1/1/AXI_ADDR_W/DATA_W/DATA_W/8/8.
REQ-015 grant  output  N_MASTERS  one-hot current owner, zero when idle.
REQ-016 busy  output  1  high while a burst is owned.

Function
REQ-017 SHALL implement states IDLE and OWN.
REQ-018 IDLE: m_valid=0, all databus_ready=0, grant=0, m_addr/m_wdata/m_wstrb/m_len driven 0.
REQ-019 IDLE with any databus_valid high: SHALL register winner index, enter OWN next edge; one-cycle arbitration bubble, m_valid earliest 1 cycle after request.
REQ-020 OWN: m_valid, m_addr, m_wdata, m_wstrb, m_len SHALL combinationally follow owner g; databus_ready[g]=m_ready, databus_last[g]=m_last; non-owners ready=0, last=0.
REQ-021 databus_rdata SHALL equal m_rdata in every state.
REQ-022 Beat completes when m_valid&&m_ready; burst ends on beat completing with m_last=1; then SHALL return to IDLE next edge.
REQ-023 Owner dropping databus_valid mid-burst: SHALL stay OWN (ownership locked until last beat); no other master served.
REQ-024 New requests from non-owners during OWN SHALL be held pending, never dropped, never forwarded.
REQ-025 Owner re-requesting in the same cycle its burst ends SHALL compete normally in the following IDLE cycle.
REQ-026 m_last asserted without m_valid&&m_ready SHALL be ignored.
REQ-027 Winner index register SHALL be clog2(N_MASTERS) bits; round-robin pointer SHALL wrap from N_MASTERS-1 to 0.
REQ-028 busy SHALL equal (state==OWN); grant SHALL be one-hot of g in OWN.

Reset
REQ-029 rst asserted at any time, including mid-burst, SHALL immediately force IDLE, round-robin pointer 0, all outputs per REQ-018, busy=0.
REQ-030 Aborted burst SHALL NOT resume after rst deasserts; arbitration restarts from IDLE.

Configuration
REQ-031 Macro VERSAT_ARB_ROUND_ROBIN_EN defined: winner SHALL be first requesting index at or above pointer (wrapping); pointer SHALL load (g+1) mod N_MASTERS on burst end.
REQ-032 VERSAT_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest requesting index wins; pointer logic SHALL be absent.

Verification
REQ-033 Single request: valid[1]=1, addr 0x1000, len 3, m_ready=1, m_last on 4th beat -> m_valid rises cycle+1, m_addr=0x1000, 4 beats to master 1, IDLE after last.
REQ-034 Contention (RR enabled): valid=3'b111 held, each burst 1 beat -> grant sequence 001,010,100,001 with one IDLE cycle between.
REQ-035 Contention (RR disabled): valid=3'b110 held -> grant always 010 while master 1 requests.
REQ-036 Lock: owner 0 drops valid after beat 1 of 4, master 2 requests -> grant stays 001, databus_ready[2]=0 until owner 0 last beat, then master 2 granted.
REQ-037 Backpressure: m_ready=0 for 5 cycles mid-burst -> m_addr/m_wdata stable, no state change, databus_ready[g]=0.
REQ-038 Reset mid-burst: rst pulsed during beat 2 of 4 -> same cycle m_valid=0, grant=0, busy=0; after release, pending masters re-arbitrated from pointer 0.
